// File: rtl/md_sched.sv
// Multiply/divide unit scheduler: owns HI/LO, runs a fixed-latency MDU op and stalls MDU users in D.
// Latency: result lands in HI/LO MULT_LAT/DIV_LAT cycles after the start cycle (visible at T+LAT+1).
// Backpressure: stall = md_use_D & busy freezes IF/ID, holds ID/EX as a bubble; EX/MEM and MEM/WB keep draining.
module md_sched #(
    parameter int MULT_LAT = 5,  // busy cycles after mult/multu start, must be 1..15
    parameter int DIV_LAT  = 10  // busy cycles after div/divu start, must be 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        en_FD,
    output logic        en_DE,
    output logic        flush_DE
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    // Op encoding: bit 1 selects divide, bit 0 selects the unsigned variant.
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // The FSM state is fully encoded by the latency counter: zero means idle.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;   // cleared for divide-by-zero so HI/LO are left untouched
    state_t      state;

    // Datapath intermediates for the result that will be parked in pend_*.
    logic        is_mul;
    logic        is_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        b_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    logic [3:0]  load_cnt;

    // Decode the counter into the named FSM state.
    always_comb begin
        state = (cnt == 4'd0) ? IDLE : RUN;
    end

    // Compute the full MDU result from the operands presented with start.
    always_comb begin
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);

        // 64-bit product: sign- or zero-extend, keep the low 64 bits.
        mul_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        mul_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = mul_a * mul_b;

        // Division on magnitudes; the quotient takes the XOR of the signs
        // and the remainder follows the dividend. 0x80000000 / -1 folds back
        // to 0x80000000 with zero remainder through the two's-complement wrap.
        a_neg  = is_signed & a[31];
        b_neg  = is_signed & b[31];
        a_mag  = a_neg ? (~a + 32'd1) : a;
        b_mag  = b_neg ? (~b + 32'd1) : b;
        b_zero = (b == 32'd0);
        b_div  = b_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

        if (is_mul) begin
            res_hi   = prod[63:32];
            res_lo   = prod[31:0];
            res_wr   = 1'b1;
            load_cnt = MULT_CNT;
        end else begin
            res_hi   = rem;
            res_lo   = quot;
            res_wr   = ~b_zero;
            load_cnt = DIV_CNT;
        end
    end

    // Latency counter, pending result and HI/LO: start wins over mt*, and
    // everything that arrives while running is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= load_cnt;
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        pend_wr <= 1'b0;
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Hazard outputs: only MDU instructions in D are held; HI/LO are never
    // forwarded from the pending result, so mfhi/mflo wait for busy to drop.
    always_comb begin
        busy     = start | (cnt != 4'd0);
        stall    = md_use_D & busy;
        en_FD    = ~stall;
        en_DE    = ~stall;
        flush_DE = stall;
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: reset, mult/div variants, mt* writes, stall and abort.
// Inputs change 1 time unit after posedge; checks sample 1 unit later.
// All expected values are hand-computed constants.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        en_FD;
    logic        en_DE;
    logic        flush_DE;

    int total;
    int bad;

    md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .md_use_D (md_use_D),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .en_FD    (en_FD),
        .en_DE    (en_DE),
        .flush_DE (flush_DE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        op       = 2'd0;
        a        = 32'd0;
        b        = 32'd0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        wdata    = 32'd0;
        md_use_D = 1'b0;
    endtask

    // Start an op this cycle and confirm busy for cycles T..T+lat and idle at
    // T+lat+1; returns positioned at T+lat+1 with inputs settled.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        tick();
        idle_inputs();
        for (int i = 1; i <= lat; i++) begin
            #1;
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            tick();
        end
        #1;
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b1;

        // Reset, with a start pulse during reset that must be ignored.
        tick();
        start = 1'b1;
        op    = 2'd2;
        a     = 32'd9;
        b     = 32'd3;
        tick();
        idle_inputs();
        reset = 1'b0;
        #1;
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_stall",    {31'd0, stall},    32'd0);
        check("rst_en_FD",    {31'd0, en_FD},    32'd1);
        check("rst_en_DE",    {31'd0, en_DE},    32'd1);
        check("rst_flush_DE", {31'd0, flush_DE}, 32'd0);
        check("rst_hi",       hi,                32'd0);
        check("rst_lo",       lo,                32'd0);
        tick();

        // mult -2*3 with mthi in the start cycle; mflo sits in D from T+1.
        start = 1'b1;
        op    = 2'd0;
        a     = 32'hFFFF_FFFE;
        b     = 32'd3;
        mthi  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        #1;
        check("mul_busy_T", {31'd0, busy}, 32'd1);
        tick();
        idle_inputs();
        for (int k = 1; k <= 5; k++) begin
            md_use_D = 1'b1;
            if (k == 2) begin
                // start and mtlo while busy must be dropped
                start = 1'b1;
                op    = 2'd1;
                a     = 32'd5;
                b     = 32'd5;
                mtlo  = 1'b1;
                wdata = 32'h5555_5555;
            end
            #1;
            check("mul_busy",  {31'd0, busy},     32'd1);
            check("mul_stall", {31'd0, stall},    32'd1);
            check("mul_en_FD", {31'd0, en_FD},    32'd0);
            check("mul_en_DE", {31'd0, en_DE},    32'd0);
            check("mul_flush", {31'd0, flush_DE}, 32'd1);
            check("mul_hi_hold", hi, 32'd0);
            check("mul_lo_hold", lo, 32'd0);
            tick();
            idle_inputs();
        end
        md_use_D = 1'b1;
        #1;
        check("mul_busy_T6",  {31'd0, busy},  32'd0);
        check("mul_stall_T6", {31'd0, stall}, 32'd0);
        check("mul_en_FD_T6", {31'd0, en_FD}, 32'd1);
        check("mul_hi", hi, 32'hFFFF_FFFF);
        check("mul_lo", lo, 32'hFFFF_FFFA);
        // Extra idle cycles: the ignored multu must not land.
        tick();
        idle_inputs();
        tick();
        #1;
        check("mul_hi_after", hi, 32'hFFFF_FFFF);
        check("mul_lo_after", lo, 32'hFFFF_FFFA);

        // divu 7/2 with a non-MDU instruction in D: never stalled.
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd7;
        b     = 32'd2;
        #1;
        check("nonmdu_stall", {31'd0, stall}, 32'd0);
        check("nonmdu_en_FD", {31'd0, en_FD}, 32'd1);
        idle_inputs();
        #1;
        run_op("divu", 2'd3, 32'd7, 32'd2, 10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // div -7/2
        run_op("div_neg_a", 2'd2, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_neg_a_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_a_hi", hi, 32'hFFFF_FFFF);

        // div 7/-2
        run_op("div_neg_b", 2'd2, 32'd7, 32'hFFFF_FFFE, 10);
        check("div_neg_b_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_b_hi", hi, 32'd1);

        // div overflow case
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        // multu max*max
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // mthi+mtlo together, then mtlo alone.
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        idle_inputs();
        #1;
        check("mt_both_hi", hi, 32'hA5A5_A5A5);
        check("mt_both_lo", lo, 32'hA5A5_A5A5);
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        idle_inputs();
        #1;
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);

        // divu by zero: full latency, HI/LO untouched.
        run_op("div0", 2'd3, 32'd99, 32'd0, 10);
        check("div0_lo", lo, 32'h0000_1234);
        check("div0_hi", hi, 32'hA5A5_A5A5);

        // Reset mid-op at cnt==4 (cycle T+7 of a DIV_LAT=10 run).
        start = 1'b1;
        op    = 2'd2;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        idle_inputs();
        for (int i = 1; i < 7; i++) tick();
        #1;
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        #1;
        check("abort_no_write_lo", lo, 32'd0);
        check("abort_no_write_hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL expose parameter MULT_LAT, default 5: busy cycles after a mult/multu start.
REQ-002 SHALL expose parameter DIV_LAT, default 10: busy cycles after a div/divu start.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  E-stage MDU start pulse.
REQ-006 op  input  2  operation code: 0 mult, 1 multu, 2 div, 3 divu; sampled with start.
REQ-007 a, b  input  32 each  operands rs/rt, sampled with start.
REQ-008 mthi, mtlo  input  1 each  E-stage write strobes for HI/LO.
REQ-009 wdata  input  32  data for mthi/mtlo.
REQ-010 md_use_D  input  1  the D-stage instruction is any MDU instruction (mult*, div*, mfhi, mflo, mthi, mtlo).
REQ-011 hi, lo  output  32 each  architectural HI/LO registers.
REQ-012 busy  output  1  MDU occupied.
REQ-013 stall  output  1  MDU structural stall request.
REQ-014 en_FD, en_DE  output  1 each  enables for the IF/ID and ID/EX pipeline registers.
REQ-015 flush_DE  output  1  ID/EX clears to a bubble (instr 0, Tnew 0).

Function
REQ-016 SHALL implement two states: IDLE (cnt==0) and RUN (cnt!=0), with a latency counter cnt of 4 bits.
REQ-017 IDLE + start SHALL load cnt with MULT_LAT (op 0/1) or DIV_LAT (op 2/3), and latch the pending result in the same edge.
REQ-018 RUN SHALL decrement cnt by 1 per cycle; on the 1->0 transition, HI/LO SHALL be written from the pending result.
REQ-019 busy SHALL be combinational: start | (cnt!=0).
REQ-020 A start at cycle T SHALL hold busy high in cycles T..T+LAT, with new HI/LO visible from cycle T+LAT+1.
REQ-021 mult SHALL produce a signed 64-bit product {hi,lo}; multu SHALL produce an unsigned 64-bit product.
REQ-022 div SHALL produce a signed quotient truncated toward zero in lo and a remainder carrying the dividend's sign in hi.
REQ-023 divu SHALL produce an unsigned quotient in lo and an unsigned remainder in hi.
REQ-024 div/divu with b==0 SHALL still run DIV_LAT cycles and SHALL leave hi/lo unchanged.
REQ-025 div with a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-026 mthi/mtlo in IDLE without start SHALL write wdata to hi/lo at the next edge; mthi and mtlo in the same cycle SHALL write both.
REQ-027 start, mthi and mtlo received while busy SHALL be ignored; the pipeline never issues these because of stall.
REQ-028 start together with mthi or mtlo in IDLE SHALL give start priority; the mt* strobe SHALL be dropped.
REQ-029 stall SHALL equal md_use_D & busy.
REQ-030 en_FD and en_DE SHALL equal ~stall, and flush_DE SHALL equal stall.
REQ-031 md_sched SHALL NOT gate the EX/MEM or MEM/WB enables; those registers stay enabled so older instructions drain.
REQ-032 Non-MDU instructions in D SHALL never be stalled by md_sched.
REQ-033 hi/lo SHALL NOT be forwarded from the pending result; mfhi/mflo read hi/lo only after busy drops.

Reset
REQ-034 While reset is high, the next edge SHALL set cnt=0, hi=0, lo=0 and clear the pending result.
REQ-035 A reset during RUN SHALL abort the operation with no HI/LO write.
REQ-036 start during a reset cycle SHALL be ignored.
REQ-037 Out of reset, outputs SHALL be busy=0, stall=0, en_FD=en_DE=1, flush_DE=0.

Verification
REQ-038 Mult case: mult a=0xFFFFFFFE (-2), b=3 at T -> busy in T..T+5, hi=0xFFFFFFFF and lo=0xFFFFFFFA at T+6.
REQ-039 Div case: divu a=7, b=2 -> lo=3, hi=1 after 10 busy cycles; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 Divide by zero: mtlo 0x1234 then divu b=0 -> busy 10 cycles, lo stays 0x1234.
REQ-041 Stall: mult at T with mflo in D at T+1 -> stall=1, en_FD=0, flush_DE=1 for T+1..T+5; mflo enters E at T+6 and reads the new lo.
REQ-042 Reset mid-op: div started, reset at cnt=4 -> hi=lo=0, busy=0 the next cycle.
REQ-043 Simultaneous events: start+mthi in IDLE -> hi takes the product, not wdata; start while busy -> cnt sequence and result unchanged.
